// File: rtl/tx_frame_pkg.sv
// Shared word-format definitions for the TX stream arbiter: type codes, the
// arbiter state encoding and the 40-bit TX word layout.
package tx_frame_pkg;

    localparam int WORD_W    = 40;
    localparam int PAYLOAD_W = 32;
    localparam int TYPE_MSB  = 39;
    localparam int TYPE_LSB  = 32;

    localparam logic [3:0] HDR_CODE_DEF  = 4'hD;
    localparam logic [3:0] DATA_CODE_DEF = 4'hE;
    localparam logic [3:0] TAIL_CODE_DEF = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } tx_state_t;

    // Type byte is {code, channel}; it sits above the 32-bit payload.
    function automatic logic [WORD_W-1:0] make_word(
        input logic [3:0]           code,
        input logic [3:0]           chan,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[TYPE_MSB:TYPE_LSB] = {code, chan};
        w[PAYLOAD_W-1:0]     = payload;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo_small.sv
// Small synchronous FIFO with show-ahead read data; buffers controller words.
// Pointers carry one extra wrap bit so full and empty are told apart.
module sync_fifo_small #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tx_stream_arbiter.sv
// Merges buffered controller words and framed Data_Block streams into one
// 40-bit TX FIFO write stream; controller words never land inside a stream.
module tx_stream_arbiter
    import tx_frame_pkg::*;
#(
    parameter int         CTRL_DEPTH = 4,
    parameter logic [3:0] HDR_CODE   = HDR_CODE_DEF,
    parameter logic [3:0] DATA_CODE  = DATA_CODE_DEF,
    parameter logic [3:0] TAIL_CODE  = TAIL_CODE_DEF
) (
    input  logic              Clock,
    input  logic              Reset_N,
    input  logic [WORD_W-1:0] Ctrl_Write_Data,
    input  logic              Ctrl_Write_Enable,
    output logic              Ctrl_Full,
    output logic              Ctrl_Overflow,
    input  logic              Communication_Data_Req,
    input  logic              Communication_Data_Enable,
    input  logic [31:0]       Communication_Data_Frame,
    output logic              Communication_Data_Full,
    input  logic [3:0]        Number_Communication,
    output logic [WORD_W-1:0] TX_FIFO_Data,
    output logic              TX_FIFO_WE,
    input  logic              TX_FIFO_FULL,
    output logic              Stream_Active,
    output logic [1:0]        State_Debug
);

    // Handshakes: a transfer happens on a rising edge where the producer's
    // valid (Enable / out_valid / Ctrl_Write_Enable) is high and the
    // consumer's full flag is low; data must be stable while valid waits.

    tx_state_t         state;
    logic              out_valid;
    logic [WORD_W-1:0] out_word;
    logic [31:0]       word_count;
    logic              overflow_q;

    logic              consume;
    logic              load_ok;
    logic              ctrl_full;
    logic              ctrl_empty;
    logic              ctrl_push;
    logic              ctrl_pop;
    logic [WORD_W-1:0] ctrl_rd_data;
    logic              stream_accept;

    assign consume  = out_valid & ~TX_FIFO_FULL;
    assign load_ok  = ~out_valid | consume;

    assign ctrl_push = Ctrl_Write_Enable & ~ctrl_full;
    // Pending stream requests win over queued controller words.
    assign ctrl_pop  = (state == IDLE) & load_ok & ~Communication_Data_Req & ~ctrl_empty;

    assign Communication_Data_Full = (state == DATA) ? (out_valid & TX_FIFO_FULL) : 1'b1;
    assign stream_accept = (state == DATA) & Communication_Data_Enable & ~Communication_Data_Full;

    sync_fifo_small #(
        .DEPTH (CTRL_DEPTH),
        .WIDTH (WORD_W)
    ) u_ctrl_fifo (
        .clk     (Clock),
        .rst_n   (Reset_N),
        .wr_en   (ctrl_push),
        .wr_data (Ctrl_Write_Data),
        .rd_en   (ctrl_pop),
        .rd_data (ctrl_rd_data),
        .full    (ctrl_full),
        .empty   (ctrl_empty)
    );

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            overflow_q <= 1'b0;
        end else if (Ctrl_Write_Enable && ctrl_full) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_word   <= '0;
            word_count <= '0;
        end else begin
            // Any load below overrides this drop of a consumed word.
            if (consume) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Communication_Data_Req && load_ok) begin
                        out_valid  <= 1'b1;
                        out_word   <= make_word(HDR_CODE, Number_Communication, 32'h0);
                        word_count <= '0;
                        state      <= DATA;
                    end else if (ctrl_pop) begin
                        out_valid <= 1'b1;
                        out_word  <= ctrl_rd_data;
                    end
                end
                DATA: begin
                    if (stream_accept) begin
                        out_valid <= 1'b1;
                        out_word  <= make_word(DATA_CODE, Number_Communication,
                                               Communication_Data_Frame);
                        if (word_count != 32'hFFFF_FFFF) word_count <= word_count + 32'd1;
                    end
                    if (!Communication_Data_Req) state <= TAIL;
                end
                TAIL: begin
                    if (load_ok) begin
                        out_valid <= 1'b1;
                        out_word  <= make_word(TAIL_CODE, Number_Communication, word_count);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign TX_FIFO_WE    = consume;
    assign TX_FIFO_Data  = out_word;
    assign Ctrl_Full     = ctrl_full;
    assign Ctrl_Overflow = overflow_q;
    assign Stream_Active = (state != IDLE);
    assign State_Debug   = state;

endmodule
